// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer: measures ms from lights-out to button press, flags jump starts/timeouts.
// Optional best-time tracking output enabled by defining F1_BEST_TIME_EN.
module f1_reaction_timer #(
  parameter logic [15:0] CYCLES_PER_MS = 16'd10000,
  parameter int          RES_W         = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lights,
  input  logic             btn,
  input  logic             ack,
  output logic [RES_W-1:0] result_ms,
  output logic             result_valid,
  output logic             jump_start,
  output logic             timeout,
`ifdef F1_BEST_TIME_EN
  output logic [RES_W-1:0] best_ms,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_TIMING = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [RES_W-1:0] MS_MAX = {RES_W{1'b1}};
  localparam logic [RES_W-1:0] MS_ONE = {{(RES_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic [7:0]       lights_q;
  logic [15:0]      pre_q, pre_d;
  logic [RES_W-1:0] ms_q, ms_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             jump_q, jump_d;
  logic             tout_q, tout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             press_s;
  logic             lights_out_s;
  logic             wrap_s;
  logic             lights_on_s;

  assign press_s      = sync2_q & ~sync3_q;
  assign lights_on_s  = (lights != 8'd0);
  assign lights_out_s = (lights_q != 8'd0) && !lights_on_s;
  assign wrap_s       = (pre_q == (CYCLES_PER_MS - 16'd1));

  // State register plus button synchroniser, edge history and light history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      lights_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      lights_q <= lights;
    end
  end

  // Next-state logic with the measurement datapath it controls
  always_comb begin
    state_d = state_q;
    pre_d   = 16'd0;
    ms_d    = ms_q;
    res_d   = res_q;
    jump_d  = jump_q;
    tout_d  = tout_q;
    case (state_q)
      S_IDLE: begin
        if (lights_on_s) state_d = S_ARMED;
        else             state_d = S_IDLE;
      end
      S_ARMED: begin
        // A press coinciding with lights-out still counts as anticipation
        if (press_s) begin
          state_d = S_DONE;
          res_d   = {RES_W{1'b0}};
          jump_d  = 1'b1;
          tout_d  = 1'b0;
        end else if (lights_out_s) begin
          state_d = S_TIMING;
          ms_d    = {RES_W{1'b0}};
        end else begin
          state_d = S_ARMED;
        end
      end
      S_TIMING: begin
        if (press_s) begin
          state_d = S_DONE;
          res_d   = ms_q;
          jump_d  = 1'b0;
          tout_d  = 1'b0;
        end else if (lights_on_s) begin
          state_d = S_ARMED;
        end else if (wrap_s) begin
          if (ms_q == MS_MAX) begin
            state_d = S_DONE;
            res_d   = MS_MAX;
            jump_d  = 1'b0;
            tout_d  = 1'b1;
          end else begin
            state_d = S_TIMING;
            ms_d    = ms_q + MS_ONE;
          end
        end else begin
          state_d = S_TIMING;
          pre_d   = pre_q + 16'd1;
        end
      end
      S_DONE: begin
        if (ack) begin
          state_d = lights_on_s ? S_ARMED : S_IDLE;
          jump_d  = 1'b0;
          tout_d  = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so status flags are registered alongside it
  always_comb begin
    valid_d = (state_d == S_DONE);
    busy_d  = (state_d == S_ARMED) || (state_d == S_TIMING);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= 16'd0;
      ms_q    <= {RES_W{1'b0}};
      res_q   <= {RES_W{1'b0}};
      jump_q  <= 1'b0;
      tout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      res_q   <= res_d;
      jump_q  <= jump_d;
      tout_q  <= tout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef F1_BEST_TIME_EN
  logic [RES_W-1:0] best_q, best_d;

  // Best time only improves on a genuine reaction, captured as the result lands
  always_comb begin
    if ((state_q != S_DONE) && (state_d == S_DONE) && !jump_d && !tout_d && (res_d < best_q)) begin
      best_d = res_d;
    end else begin
      best_d = best_q;
    end
  end

  // Best-time register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) best_q <= MS_MAX;
    else     best_q <= best_d;
  end

  assign best_ms = best_q;
`endif

  assign result_ms    = res_q;
  assign result_valid = valid_q;
  assign jump_start   = jump_q;
  assign timeout      = tout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Scoreboard bench for f1_reaction_timer (CYCLES_PER_MS=10, RES_W=10).
module tb_f1_reaction_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lights;
  logic       btn;
  logic       ack;
  logic [9:0] result_ms;
  logic       result_valid;
  logic       jump_start;
  logic       timeout;
  logic       busy;
`ifdef F1_BEST_TIME_EN
  logic [9:0] best_ms;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] ms;
    logic       jump;
    logic       tout;
  } exp_t;

  exp_t exp_q[$];

  f1_reaction_timer #(.CYCLES_PER_MS(16'd10), .RES_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .lights       (lights),
    .btn          (btn),
    .ack          (ack),
    .result_ms    (result_ms),
    .result_valid (result_valid),
    .jump_start   (jump_start),
    .timeout      (timeout),
`ifdef F1_BEST_TIME_EN
    .best_ms      (best_ms),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pops an expectation on every rising result_valid and checks the result stays frozen while held
  task automatic monitor();
    logic prev_v;
    exp_t e;
    exp_t held;
    prev_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (result_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got ms=%0h jump=%0b tout=%0b expected none",
                   result_ms, jump_start, timeout);
          held = {result_ms, jump_start, timeout};
        end else begin
          e    = exp_q.pop_front();
          held = e;
          check("sb_result_ms", {22'd0, result_ms}, {22'd0, e.ms});
          check("sb_jump_start", {31'd0, jump_start}, {31'd0, e.jump});
          check("sb_timeout", {31'd0, timeout}, {31'd0, e.tout});
        end
      end else if (result_valid && prev_v) begin
        check("hold_stable", {20'd0, result_ms, jump_start, timeout}, {20'd0, held});
      end
      prev_v = result_valid;
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!result_valid && n < budget) begin
      tick();
      n++;
    end
    check("valid_within_budget", {31'd0, result_valid}, 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_clears_valid", {31'd0, result_valid}, 32'd0);
    check("ack_clears_jump", {31'd0, jump_start}, 32'd0);
    check("ack_clears_timeout", {31'd0, timeout}, 32'd0);
  endtask

  // Light build-up 01..FF, lights-out, then a button press d cycles later
  task automatic run_timed(input int d, input logic [9:0] ms);
    exp_t e;
    lights = 8'h00;
    for (int i = 0; i < 8; i++) begin
      lights = {lights[6:0], 1'b1};
      repeat (3) tick();
    end
    check("busy_armed", {31'd0, busy}, 32'd1);
    lights = 8'h00;
    repeat (d) tick();
    e.ms = ms; e.jump = 1'b0; e.tout = 1'b0;
    exp_q.push_back(e);
    btn = 1'b1;
    wait_valid(20);
    check("busy_low_in_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    rst    = 1'b1;
    lights = 8'h00;
    btn    = 1'b0;
    ack    = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check("rst_jump_start", {31'd0, jump_start}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result_ms", {22'd0, result_ms}, 32'd0);
`ifdef F1_BEST_TIME_EN
    check("best_reset", {22'd0, best_ms}, 32'h3FF);
`endif
    rst = 1'b0;
    repeat (3) tick();

    run_timed(403, 10'd40);
    btn = 1'b0;
    repeat (4) tick();
    do_ack();
`ifdef F1_BEST_TIME_EN
    check("best_after_40", {22'd0, best_ms}, 32'd40);
`endif
    repeat (4) tick();

    run_timed(253, 10'd25);
    btn = 1'b0;
    repeat (4) tick();
    do_ack();
`ifdef F1_BEST_TIME_EN
    check("best_after_25", {22'd0, best_ms}, 32'd25);
`endif
    repeat (4) tick();

    lights = 8'h1F;
    repeat (3) tick();
    check("jump_busy_armed", {31'd0, busy}, 32'd1);
    e.ms = 10'd0; e.jump = 1'b1; e.tout = 1'b0;
    exp_q.push_back(e);
    btn = 1'b1;
    wait_valid(10);
    lights = 8'h00;
    repeat (20) tick();
    check("jump_lights_out_ignored", {31'd0, result_valid}, 32'd1);
    check("jump_not_busy", {31'd0, busy}, 32'd0);
    btn = 1'b0;
    repeat (4) tick();
    do_ack();
    check("jump_idle_after_ack", {31'd0, busy}, 32'd0);
`ifdef F1_BEST_TIME_EN
    check("best_after_jump", {22'd0, best_ms}, 32'd25);
`endif
    repeat (4) tick();

    run_timed(303, 10'd30);
    btn = 1'b0;
    lights = 8'hFF;
    repeat (50) tick();
    check("held_valid_50", {31'd0, result_valid}, 32'd1);
    check("held_ms_50", {22'd0, result_ms}, 32'd30);
    do_ack();
    check("armed_after_ack", {31'd0, busy}, 32'd1);
`ifdef F1_BEST_TIME_EN
    check("best_after_30", {22'd0, best_ms}, 32'd25);
`endif
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("second_ack_busy", {31'd0, busy}, 32'd1);
    check("second_ack_valid", {31'd0, result_valid}, 32'd0);

    lights = 8'h00;
    repeat (50) tick();
    check("timing_busy", {31'd0, busy}, 32'd1);
    lights = 8'hFF;
    repeat (3) tick();
    check("relight_busy", {31'd0, busy}, 32'd1);
    check("relight_no_result", {31'd0, result_valid}, 32'd0);
    lights = 8'h00;
    e.ms = 10'h3FF; e.jump = 1'b0; e.tout = 1'b1;
    exp_q.push_back(e);
    wait_valid(10300);
    do_ack();
`ifdef F1_BEST_TIME_EN
    check("best_after_timeout", {22'd0, best_ms}, 32'd25);
`endif
    repeat (4) tick();

    lights = 8'hFF;
    repeat (2) tick();
    lights = 8'h00;
    repeat (100) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, result_valid}, 32'd0);
    check("midrst_jump", {31'd0, jump_start}, 32'd0);
    check("midrst_timeout", {31'd0, timeout}, 32'd0);
    check("midrst_ms", {22'd0, result_ms}, 32'd0);
`ifdef F1_BEST_TIME_EN
    check("midrst_best", {22'd0, best_ms}, 32'h3FF);
`endif
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_valid", {31'd0, result_valid}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
